fxp_accumulator: RTL
====================

Name: fxp_accumulator

Overview:
- Streaming signed accumulator directly downstream of the Q3.4 x Q3.4 fixed-point multiplier.
- Consumes its 8-bit two's-complement Q6.1 products one per beat and sums a burst of up to MAX_LEN products (a dot product).
- Returns the burst sum both full-width and saturated back to 8-bit Q6.1, for the next multiply/compress stage.
- valid/ready handshake on both sides.

Parameters:
MAX_LEN, 16, maximum products per burst; a burst auto-terminates at MAX_LEN beats.
ACC_W, 12, accumulator width (Q(ACC_W-2).1); must satisfy ACC_W >= 8 + clog2(MAX_LEN), so the internal sum never overflows.
CNT_W, 5, beat counter width; must hold MAX_LEN.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data/in_last are valid this cycle.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  8  signed product, Q6.1 two's complement (sign[7], integer[6:1], fraction[0]).
in_last  input  1  final beat of the current burst.
out_valid  output  1  burst result available.
out_ready  input  1  downstream accepts the result.
out_data  output  8  saturated burst sum, Q6.1.
out_acc  output  ACC_W  unsaturated burst sum, Q(ACC_W-2).1.
out_sat  output  1  out_data was clamped.
out_count  output  CNT_W  number of beats in the burst (1..MAX_LEN).

Behaviour:
- Reset (rst=1 at a clock edge, including mid-burst or while holding a result):
  - state=ACC; acc=0, cnt=0.
  - out_valid=0, out_data=0, out_acc=0, out_sat=0, out_count=0.
  - in_ready=1 from the first cycle after reset.
  - A partial burst is discarded.
- State ACC:
  - in_ready=1, out_valid=0.
  - On a handshake (in_valid & in_ready): acc_n = acc + sign_extend(in_data, ACC_W) and cnt_n = cnt+1.
  - If in_last=1 or cnt_n==MAX_LEN:
    - latch out_acc=acc_n and out_count=cnt_n;
    - out_data = 0x7F if acc_n>127, 0x80 if acc_n<-128, else acc_n[7:0];
    - out_sat=1 if clamped, else 0;
    - clear acc and cnt; next state DONE.
  - Otherwise acc=acc_n, cnt=cnt_n, stay in ACC.
  - No handshake: all state held.
- State DONE:
  - in_ready=0, out_valid=1; out_* held stable until accepted.
  - out_ready=1: next state ACC; out_valid drops the following cycle. The next burst can start the cycle after acceptance (one bubble cycle per burst).
  - out_ready=0: hold indefinitely; in_valid is ignored and no beat is consumed.
- Latency: result is visible (out_valid=1) in the cycle after the last beat's handshake.
- Single-beat burst (in_last on the first beat) is legal: out_acc = sign_extend(in_data), out_count=1.
- out_ready while out_valid=0 has no effect.
- in_last asserted on the MAX_LEN-th beat terminates once, identical to plain auto-termination.
- Arithmetic:
  - Pure two's-complement addition; no rounding, because the fraction LSB is preserved.
  - Saturation applies only on the 8-bit output path; out_acc is always exact.

Decomposition:
- Shared package fxp_pkg:
  - Q6.1 width constant (8);
  - Q6.1 max/min constants 8'h7F / 8'h80;
  - state enum {ACC, DONE};
  - function sat_q61(acc) returning {sat_flag, q61}.
- One natural sub-module: fxp_sat_q61, a combinational clamp from ACC_W to 8 bits with a flag. It is reused by later stages that narrow wide sums.
- FSM, counter and accumulator stay in fxp_accumulator.

Test Plan:
- Basic burst: beats 0x06 (3.0), 0x04 (2.0), 0xFA (-3.0, in_last), out_ready=1 → one cycle later out_valid=1, out_data=0x04, out_acc=0x004, out_sat=0, out_count=3.
- Positive saturation: 16 beats of 0x7F, no in_last → auto-terminates after beat 16; out_acc=0x7F0, out_data=0x7F, out_sat=1, out_count=16.
- Negative saturation: beats 0x80, 0x80 (in_last) → out_acc=0xF00 (-256), out_data=0x80, out_sat=1, out_count=2.
- Backpressure: complete a burst, hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=0x02 → in_ready=0 and outputs stable throughout. Then out_ready=1 → the next burst starts from acc=0, and the held 0x02 beat is counted only after the bubble.
- Reset mid-burst: accept 0x10, 0x10, assert rst for 1 cycle, then send 0x02 (in_last) → out_acc=0x002, out_count=1, with no residue from the aborted burst.
- Single-beat and boundary: single beat 0xFF (-0.5, in_last) → out_data=0xFF, out_sat=0. Beats 0x7F, 0x01 (in_last) → out_acc=0x080 (128), out_data=0x7F, out_sat=1.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared Q6.1 definitions for the fixed-point multiply/accumulate pipeline.
// Holds the 8-bit Q6.1 format constants, the accumulator FSM states and the narrowing clamp.
package fxp_pkg;

   localparam int unsigned Q61Width = 8;
   localparam logic [Q61Width-1:0] Q61Max = 8'h7F;
   localparam logic [Q61Width-1:0] Q61Min = 8'h80;

   typedef enum logic [0:0] {StAcc, StDone} acc_state_e;

   // Callers sign-extend their sum to 32 bits first; returns {sat_flag, q61}.
   function automatic logic [Q61Width:0] sat_q61(input logic signed [31:0] acc);
      if (acc > 32'sd127) begin
         return {1'b1, Q61Max};
      end else if (acc < -32'sd128) begin
         return {1'b1, Q61Min};
      end else begin
         return {1'b0, acc[Q61Width-1:0]};
      end
   endfunction

endpackage

// File: rtl/fxp_sat_q61.sv
// Combinational clamp of a signed ACC_W-bit Q(ACC_W-2).1 sum down to 8-bit Q6.1.
// Asserts sat when the value had to be clamped to 0x7F or 0x80.
module fxp_sat_q61
   import fxp_pkg::*;
#(
   parameter int unsigned ACC_W = 12
) (
   input  logic [ACC_W-1:0]    acc,
   output logic [Q61Width-1:0] q61,
   output logic                sat
);

   logic signed [31:0] acc_wide;

   assign acc_wide = 32'($signed(acc));

   always_comb begin
      {sat, q61} = sat_q61(acc_wide);
   end

endmodule

// File: rtl/fxp_accumulator.sv
// Streaming signed accumulator for Q6.1 products: sums a burst of up to MAX_LEN beats and
// returns the exact sum plus a saturated Q6.1 copy over a valid/ready handshake.
module fxp_accumulator
   import fxp_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned ACC_W   = 12,
   parameter int unsigned CNT_W   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [Q61Width-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [Q61Width-1:0] out_data,
   output logic [ACC_W-1:0]    out_acc,
   output logic                out_sat,
   output logic [CNT_W-1:0]    out_count
);

   acc_state_e          state_q;
   logic [ACC_W-1:0]    acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ACC_W-1:0]    acc_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                burst_end;
   logic [Q61Width-1:0] sat_data;
   logic                sat_flag;

   assign acc_d     = acc_q + {{(ACC_W-Q61Width){in_data[Q61Width-1]}}, in_data};
   assign cnt_d     = cnt_q + 1'b1;
   assign burst_end = in_last || (cnt_d == CNT_W'(MAX_LEN));

   fxp_sat_q61 #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc (acc_d),
      .q61 (sat_data),
      .sat (sat_flag)
   );

   // in_ready/out_valid are registered and always mirror the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StAcc;
         acc_q     <= '0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_acc   <= '0;
         out_sat   <= 1'b0;
         out_count <= '0;
      end else begin
         case (state_q)
            StAcc: begin
               if (in_valid && in_ready) begin
                  if (burst_end) begin
                     out_acc   <= acc_d;
                     out_count <= cnt_d;
                     out_data  <= sat_data;
                     out_sat   <= sat_flag;
                     acc_q     <= '0;
                     cnt_q     <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_d;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  state_q   <= StAcc;
               end
            end
            default: begin
               state_q   <= StAcc;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
